// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the multi-lane immediate generator.
// Holds format codes, RV32I/RV64I opcodes and the opcode classifier.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    imm_type_e fmt;
    logic      legal;
  } fmt_info_t;

  // Every legal opcode ends in 2'b11, so compressed encodings fall to default.
  function automatic fmt_info_t classify_opcode(input logic [6:0] opcode);
    fmt_info_t info;
    info = '{fmt: IMM_NONE, legal: 1'b1};
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: info.fmt = IMM_I;
      OP_STORE:         info.fmt = IMM_S;
      OP_BRANCH:        info.fmt = IMM_B;
      OP_LUI, OP_AUIPC: info.fmt = IMM_U;
      OP_JAL:           info.fmt = IMM_J;
      OP_REG:           info.fmt = IMM_NONE;
      default:          info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/imm_decode_lane.sv
// Combinational single-lane immediate extractor.
// Produces the sign-extended immediate, its format code and an illegal flag.
module imm_decode_lane
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic            lane_valid,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_type,
  output logic            illegal
);

  fmt_info_t   info;
  logic [31:0] imm32;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    info  = classify_opcode(instr[6:0]);
    imm32 = '0;
    case (info.fmt)
      IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
      IMM_U:   imm32 = {instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    imm      = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    if (lane_valid) begin
      imm      = XLEN'($signed(imm32));
      imm_type = info.fmt;
      illegal  = !info.legal;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered multi-lane immediate generator with a 2-entry skid buffer,
// synchronous flush and a saturating illegal-lane counter.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES-1:0]      in_lane_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES*3-1:0]    out_imm_type,
  output logic [LANES-1:0]      out_illegal,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [CNT_W-1:0]      illegal_count
);

  localparam int IW = LANES * XLEN;
  localparam int TW = LANES * 3;
  localparam int SW = CNT_W + 3;

  logic [IW-1:0]    dec_imm;
  logic [TW-1:0]    dec_type;
  logic [LANES-1:0] dec_ill;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    imm_decode_lane #(.XLEN(XLEN)) u_dec (
      .instr     (in_instr[32*k +: 32]),
      .lane_valid(in_lane_valid[k]),
      .imm       (dec_imm[XLEN*k +: XLEN]),
      .imm_type  (dec_type[3*k +: 3]),
      .illegal   (dec_ill[k])
    );
  end

  logic             skid_valid;
  logic [IW-1:0]    skid_imm;
  logic [TW-1:0]    skid_type;
  logic [LANES-1:0] skid_ill;
  logic [LANES-1:0] skid_lv;

  logic in_fire;
  logic out_fire;
  logic out_free;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign out_free = !out_valid || out_ready;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      // NOTE: payload registers are reset too, so outputs read zero after reset rather than stale data.
      out_imm        <= '0;
      out_imm_type   <= '0;
      out_illegal    <= '0;
      out_lane_valid <= '0;
      skid_valid     <= 1'b0;
      skid_imm       <= '0;
      skid_type      <= '0;
      skid_ill       <= '0;
      skid_lv        <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      // Skid holds the older beat, so it drains before any new input.
      if (skid_valid) begin
        out_valid      <= 1'b1;
        out_imm        <= skid_imm;
        out_imm_type   <= skid_type;
        out_illegal    <= skid_ill;
        out_lane_valid <= skid_lv;
        skid_valid     <= 1'b0;
      end else if (in_fire) begin
        out_valid      <= 1'b1;
        out_imm        <= dec_imm;
        out_imm_type   <= dec_type;
        out_illegal    <= dec_ill;
        out_lane_valid <= in_lane_valid;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
      skid_imm   <= dec_imm;
      skid_type  <= dec_type;
      skid_ill   <= dec_ill;
      skid_lv    <= in_lane_valid;
    end
  end

  logic [SW-1:0] illegal_pop;
  logic [SW-1:0] count_sum;

  always_comb begin
    illegal_pop = '0;
    for (int k = 0; k < LANES; k++) begin
      illegal_pop = illegal_pop + SW'(out_illegal[k] & out_lane_valid[k]);
    end
    count_sum = SW'(illegal_count) + illegal_pop;
  end

  // Counts beats the consumer actually took; flush leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (out_fire) begin
      illegal_count <= (|count_sum[SW-1:CNT_W]) ? '1 : count_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed beats push expected results,
// monitors pop and compare whenever a DUT presents an output beat.
module tb_imm_gen_pipe;

  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2,
                         T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

  typedef struct {
    logic [63:0] imm0;
    logic [63:0] imm1;
    logic [2:0]  t0;
    logic [2:0]  t1;
    logic [1:0]  ill;
    logic [1:0]  lv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_instr = '0;
  logic [1:0]  in_lane_valid = '0;

  logic        in_ready, out_valid;
  logic [63:0] out_imm;
  logic [5:0]  out_imm_type;
  logic [1:0]  out_illegal, out_lane_valid;
  logic [3:0]  illegal_count;

  logic         in_ready64, out_valid64;
  logic [127:0] out_imm64;
  logic [5:0]   out_imm_type64;
  logic [1:0]   out_illegal64, out_lane_valid64;
  logic [15:0]  illegal_count64;

  int   n_checks = 0;
  int   n_fail = 0;
  bit   chk64 = 1'b0;
  exp_t q[$];
  exp_t q64[$];
  exp_t em, e6;

  always #5 clk = ~clk;

  imm_gen_pipe #(.LANES(2), .XLEN(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_lane_valid(in_lane_valid), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_imm_type(out_imm_type),
    .out_illegal(out_illegal), .out_lane_valid(out_lane_valid), .illegal_count(illegal_count)
  );

  imm_gen_pipe #(.LANES(2), .XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_lane_valid(in_lane_valid), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_imm_type(out_imm_type64),
    .out_illegal(out_illegal64), .out_lane_valid(out_lane_valid64),
    .illegal_count(illegal_count64)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] m0, input logic [2:0] a0,
                              input logic [63:0] m1, input logic [2:0] a1,
                              input logic [1:0] il, input logic [1:0] v);
    exp_t e;
    e.imm0 = m0; e.t0 = a0; e.imm1 = m1; e.t1 = a1; e.ill = il; e.lv = v;
    return e;
  endfunction

  // Main monitor: compares the head on every presented beat, pops on fire.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_beat", out_valid, 1'b0);
      end else begin
        em = q[0];
        check("imm", out_imm, {em.imm1[31:0], em.imm0[31:0]});
        check("imm_type", out_imm_type, {em.t1, em.t0});
        check("illegal", out_illegal, em.ill);
        check("lane_valid", out_lane_valid, em.lv);
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk64 && out_valid64 && out_ready) begin
      if (q64.size() == 0) begin
        check("unexpected_beat64", out_valid64, 1'b0);
      end else begin
        e6 = q64.pop_front();
        check("imm64", out_imm64, {e6.imm1, e6.imm0});
        check("imm_type64", out_imm_type64, {e6.t1, e6.t0});
      end
    end
  end

  task automatic send(input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] lv, input exp_t e);
    bit ok = 1'b0;
    in_instr = {i1, i0};
    in_lane_valid = lv;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        q.push_back(e);
        if (chk64) q64.push_back(e);
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) check("send_accept", ok, 1'b1);
  endtask

  task automatic drain();
    for (int c = 0; c < 60 && (q.size() != 0 || q64.size() != 0); c++) @(posedge clk);
    #1;
    check("drain_empty", q.size() + q64.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    q64.delete();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_imm", out_imm, 64'h0);
    check("rst_imm_type", out_imm_type, 6'h0);
    check("rst_illegal", {out_illegal, out_lane_valid}, 4'h0);
    check("rst_count", illegal_count, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Format decode, one cycle latency, then back-to-back beats.
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h0020A423, 2'b11,
         mk(64'hFFFFFFFF, T_I, 64'h00000008, T_S, 2'b00, 2'b11));
    check("latency_out_valid", out_valid, 1'b1);
    send(32'hFE000EE3, 32'h123450B7, 2'b11,
         mk(64'hFFFFFFFC, T_B, 64'h12345000, T_U, 2'b00, 2'b11));
    send(32'h0000006F, 32'h00000033, 2'b11,
         mk(64'h0, T_J, 64'h0, T_NONE, 2'b00, 2'b11));
    send(32'h8000006F, 32'h00100073, 2'b11,
         mk(64'hFFF00000, T_J, 64'h00000001, T_I, 2'b00, 2'b11));
    drain();

    // 64-bit immediates on the wide instance.
    chk64 = 1'b1;
    send(32'h80000037, 32'h7FF00093, 2'b11,
         mk(64'hFFFFFFFF80000000, T_U, 64'h00000000000007FF, T_I, 2'b00, 2'b11));
    drain();
    chk64 = 1'b0;

    // Backpressure: A held, B into skid, C waits for space.
    send(32'h00500093, 32'h00A00013, 2'b11,
         mk(64'h5, T_I, 64'hA, T_I, 2'b00, 2'b11));
    out_ready = 1'b0;
    send(32'h00001537, 32'hFE000EE3, 2'b11,
         mk(64'h00001000, T_U, 64'hFFFFFFFC, T_B, 2'b00, 2'b11));
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_in_ready64", in_ready64, 1'b0);
    fork
      send(32'h0000006F, 32'h00000033, 2'b11,
           mk(64'h0, T_J, 64'h0, T_NONE, 2'b00, 2'b11));
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_held_valid", out_valid, 1'b1);
        out_ready = 1'b1;
      end
    join
    drain();

    // Masked lane with illegal bits; unmasked lane illegal.
    do_reset();
    out_ready = 1'b1;
    send(32'h00000000, 32'hFFFFFFFF, 2'b01,
         mk(64'h0, T_NONE, 64'h0, T_NONE, 2'b01, 2'b01));
    @(posedge clk);
    #1;
    check("mask_count", illegal_count, 4'd1);
    check("mask_count64", illegal_count64, 16'd1);

    // Flush with output and skid full; the flush-cycle beat is dropped.
    do_reset();
    out_ready = 1'b0;
    send(32'h00500093, 32'hFFFFFFFF, 2'b11,
         mk(64'h5, T_I, 64'h0, T_NONE, 2'b10, 2'b11));
    send(32'h00001537, 32'h00000000, 2'b11,
         mk(64'h00001000, T_U, 64'h0, T_NONE, 2'b10, 2'b11));
    check("pre_flush_in_ready", in_ready, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1;
    in_instr = {32'h00A00013, 32'h00700093};
    in_lane_valid = 2'b11;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    q.delete();
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_in_ready", in_ready, 1'b1);
    check("flush_count", illegal_count, 4'd0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(32'h0020A423, 32'h0000006F, 2'b11,
         mk(64'h8, T_S, 64'h0, T_J, 2'b00, 2'b11));
    drain();

    // Saturation: 14 illegal lanes, then 6 more stopping at 15.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++)
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11,
           mk(64'h0, T_NONE, 64'h0, T_NONE, 2'b11, 2'b11));
    drain();
    check("count_14", illegal_count, 4'd14);
    for (int i = 0; i < 3; i++)
      send(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11,
           mk(64'h0, T_NONE, 64'h0, T_NONE, 2'b11, 2'b11));
    drain();
    check("count_sat", illegal_count, 4'd15);

    // Reset mid-transfer clears everything immediately.
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 32'h00500093, 2'b11,
         mk(64'h0, T_NONE, 64'h5, T_I, 2'b01, 2'b11));
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_count", illegal_count, 4'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_lane_valid", out_lane_valid, 2'b00);
    q.delete();
    q64.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
